axi_mem_scheduler: RTL

//  Sequences the shared single-port word buffer behind axi_slave_interface. Queues its one-cycle

---
 rtl/axi_mem_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/axi_mem_scheduler.sv
// axi_mem_scheduler: shares a single-port word buffer between queued slave writes and read bursts,
// returning read data one beat at a time. Writes have priority over reads at the memory port.
// Ports: clk, reset (async, active-low); wr_req/wr_addr/wr_data write pulse in;
// rd_req/rd_addr/rd_burst read request in; send/MDATA_out/send_done beat handshake;
// mem_en/mem_we/mem_addr/mem_wdata/mem_rdata memory port; busy, wr_overflow, rd_drop status.
// Optional build macro SCHED_TIMEOUT_EN adds the RD_ACK timeout and the sticky rd_timeout output.
module axi_mem_scheduler #(
  parameter int WQ_DEPTH = 4,
  parameter int ADDR_W   = 6,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [7:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_req,
  input  logic [7:0]        rd_addr,
  input  logic [3:0]        rd_burst,
  input  logic              send_done,
  output logic              send,
  output logic [31:0]       MDATA_out,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              wr_overflow,
`ifdef SCHED_TIMEOUT_EN
  output logic              rd_timeout,
`endif
  output logic              rd_drop
);

  localparam int PW = $clog2(WQ_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_RD_ISSUE, S_RD_DATA, S_RD_ACK
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wq_addr [WQ_DEPTH];
  logic [31:0]       r_wq_data [WQ_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW:0]       r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_beats;
`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     r_tmo;
`endif

  logic w_full;
  logic w_deq;
  logic w_enq;

  assign w_full = (r_count == (PW+1)'(WQ_DEPTH));
  // RD_DATA samples the read data, so the port must stay quiet there
  assign w_deq  = (r_count != '0) && (r_state != S_RD_DATA);
  // a full queue still accepts when the head leaves in the same cycle
  assign w_enq  = wr_req && (!w_full || w_deq);

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_wq_addr[r_wptr] <= ADDR_W'(wr_addr[7:2]);
      r_wq_data[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_addr      <= '0;
      r_beats     <= '0;
      send        <= 1'b0;
      MDATA_out   <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      wr_overflow <= 1'b0;
      rd_drop     <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      r_tmo       <= '0;
      rd_timeout  <= 1'b0;
`endif
    end else begin
      if (w_enq) r_wptr <= r_wptr + PW'(1);
      if (w_deq) r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + (PW+1)'(w_enq) - (PW+1)'(w_deq);
      if (wr_req && !w_enq) wr_overflow <= 1'b1;
      if (rd_req && (r_state != S_IDLE)) rd_drop <= 1'b1;

      send   <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if (w_deq) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= r_wq_addr[r_rptr];
        mem_wdata <= r_wq_data[r_rptr];
      end

      case (r_state)
        S_IDLE: begin
          if (rd_req) begin
            r_addr  <= ADDR_W'(rd_addr[7:2]);
            r_beats <= (rd_burst == 4'd0) ? 4'd1 : rd_burst;
            r_state <= S_RD_ISSUE;
            busy    <= 1'b1;
          end
        end
        S_RD_ISSUE: begin
          // only an empty queue frees the port, so queued writes land first
          if (r_count == '0) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= r_addr;
            r_state  <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          MDATA_out <= mem_rdata;
          send      <= 1'b1;
          r_addr    <= r_addr + ADDR_W'(1);
          r_beats   <= r_beats - 4'd1;
          r_state   <= S_RD_ACK;
        end
        S_RD_ACK: begin
          if (send_done) begin
            r_state <= (r_beats == 4'd0) ? S_IDLE : S_RD_ISSUE;
            busy    <= (r_beats != 4'd0);
`ifdef SCHED_TIMEOUT_EN
            r_tmo   <= '0;
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            r_tmo      <= '0;
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            rd_timeout <= 1'b1;
          end else begin
            r_tmo <= r_tmo + TW'(1);
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
